tm1638_responder: RTL and testbench

TM1638_RESPONDER -- requirements
Module: tm1638_responder

---
 rtl/tm1638_pkg.sv | 27 ++
 rtl/spi_pin_sync.sv | 33 +++
 rtl/tm1638_responder.sv | 154 +++++++++++++++
 tb/tb_tm1638_responder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// Shared types and command-decode constants for the TM1638 serial responder.
package tm1638_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ,
    S_IGNORE
  } state_t;

  // Command class lives in bits 7:6 of the first byte of a transaction.
  localparam logic [1:0] CLASS_DATA = 2'b01;
  localparam logic [1:0] CLASS_CTRL = 2'b10;
  localparam logic [1:0] CLASS_ADDR = 2'b11;

  localparam int FIXED_BIT = 2;
  localparam int READ_BIT  = 1;

  // Key byte k carries key k in bit 0 and key k+4 in bit 4.
  function automatic logic [7:0] key_byte(input logic [7:0] keys, input logic [1:0] k);
    key_byte    = 8'h00;
    key_byte[0] = keys[{1'b0, k}];
    key_byte[4] = keys[{1'b1, k}];
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one serial pin, with edge strobes derived from the synchronized level.
module spi_pin_sync #(
  parameter int   STAGES = 2,
  parameter logic IDLE   = 1'b1
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // NOTE: every register here is updated with <= so all flops sample the
  // pre-edge values together; blocking assignments would collapse the chain.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      chain <= {STAGES{IDLE}};
      prev  <= IDLE;
    end else begin
      chain <= STAGES'({chain, din});
      prev  <= level;
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638-compatible slave: decodes host commands, holds display memory and
// control settings, and shifts out a snapshot of the key matrix on reads.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int NUM_MEM_BYTES = 16,
  parameter int NUM_KEY_BYTES = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cs,
  input  logic       sck,
  input  logic       dio_i,
  output logic       dio_o,
  output logic       dio_e,
  input  logic [7:0] key_state,
  input  logic [3:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       display_on,
  output logic [2:0] brightness,
  output logic       frame_done,
  output logic       cmd_error
);

  state_t     state;
  logic       cs_lvl, cs_rise, cs_fall;
  logic       sck_lvl, sck_rise, sck_fall;
  logic       dio_lvl, dio_rise, dio_fall;
  logic [7:0] mem [NUM_MEM_BYTES];
  logic [7:0] shreg, rx_byte, snap, key_out;
  logic [7:0] rd_byte;
  logic [2:0] bit_cnt, rd_bit;
  logic [3:0] addr, settle;
  logic       fixed, wrote;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_cs_sync (
    .CLOCK_50(CLOCK_50), .reset(reset), .din(cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sck_sync (
    .CLOCK_50(CLOCK_50), .reset(reset), .din(sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_dio_sync (
    .CLOCK_50(CLOCK_50), .reset(reset), .din(dio_i),
    .level(dio_lvl), .rise(dio_rise), .fall(dio_fall)
  );

  logic unused_pins;
  assign unused_pins = &{1'b0, sck_lvl, dio_rise, dio_fall};

  // LSB first: the newest bit enters at the top, so after 8 shifts bit 0 is the first bit sent.
  assign rx_byte  = {dio_lvl, shreg[7:1]};
  assign mem_data = mem[mem_addr];

  always_comb begin
    key_out = 8'h00;
    if (rd_byte < 8'(NUM_KEY_BYTES) && rd_byte < 8'd4)
      key_out = key_byte(snap, rd_byte[1:0]);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state      <= S_IDLE;
      dio_o      <= 1'b0;
      dio_e      <= 1'b0;
      display_on <= 1'b0;
      brightness <= 3'd0;
      frame_done <= 1'b0;
      cmd_error  <= 1'b0;
      shreg      <= 8'h00;
      snap       <= 8'h00;
      rd_byte    <= 8'h00;
      bit_cnt    <= 3'd0;
      rd_bit     <= 3'd0;
      addr       <= 4'd0;
      fixed      <= 1'b0;
      wrote      <= 1'b0;
      // A CS held low through reset still shows up as a fall once the
      // synchronizer flushes; ignore that one so a fresh fall is required.
      settle     <= 4'(SYNC_STAGES + 1);
      // NOTE: the display memory is reset explicitly because the host relies
      // on a blank display after reset; this keeps it in flops, not RAM.
      for (int i = 0; i < NUM_MEM_BYTES; i++) mem[i] <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      cmd_error  <= 1'b0;
      if (settle != 4'd0) settle <= settle - 4'd1;

      if (cs_rise) begin
        state      <= S_IDLE;
        dio_e      <= 1'b0;
        dio_o      <= 1'b0;
        frame_done <= wrote;
        wrote      <= 1'b0;
      end else if (cs_fall && settle == 4'd0) begin
        state   <= S_CMD;
        bit_cnt <= 3'd0;
        wrote   <= 1'b0;
      end else if (state != S_IDLE && !cs_lvl) begin
        if (sck_rise) begin
          shreg   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              S_CMD: begin
                case (rx_byte[7:6])
                  CLASS_DATA: begin
                    fixed <= rx_byte[FIXED_BIT];
                    if (rx_byte[READ_BIT]) begin
                      snap    <= key_state;
                      rd_byte <= 8'h00;
                      rd_bit  <= 3'd0;
                      dio_e   <= 1'b1;
                      state   <= S_READ;
                    end else begin
                      state <= S_IGNORE;
                    end
                  end
                  CLASS_ADDR: begin
                    addr  <= rx_byte[3:0];
                    state <= S_WRITE;
                  end
                  CLASS_CTRL: begin
                    display_on <= rx_byte[3];
                    brightness <= rx_byte[2:0];
                    state      <= S_IGNORE;
                  end
                  default: begin
                    cmd_error <= 1'b1;
                    state     <= S_IGNORE;
                  end
                endcase
              end
              S_WRITE: begin
                mem[addr] <= rx_byte;
                wrote     <= 1'b1;
                if (!fixed) addr <= addr + 4'd1;
              end
              default: ;
            endcase
          end
        end
        if (sck_fall && state == S_READ) begin
          dio_o  <= key_out[rd_bit];
          rd_bit <= rd_bit + 3'd1;
          if (rd_bit == 3'd7 && rd_byte < 8'(NUM_KEY_BYTES)) rd_byte <= rd_byte + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: drives host transactions bit by bit and checks
// against a transaction-level model of display memory, settings and key bytes.
module tb_tm1638_responder;

  localparam int HALF = 6;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b1, sck = 1'b1, dio_i = 1'b1;
  logic       dio_o, dio_e;
  logic [7:0] key_state = 8'h00;
  logic [3:0] mem_addr = 4'd0;
  logic [7:0] mem_data;
  logic       display_on;
  logic [2:0] brightness;
  logic       frame_done, cmd_error;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_mem [16];
  logic       m_fixed, m_on;
  logic [2:0] m_bright;
  int         m_frames = 0, m_cmd_errs = 0;
  int         seen_frames = 0, seen_cmd_errs = 0;
  logic [7:0] tx_q [$];

  always #10 CLOCK_50 = ~CLOCK_50;

  tm1638_responder dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .cs(cs), .sck(sck), .dio_i(dio_i),
    .dio_o(dio_o), .dio_e(dio_e), .key_state(key_state), .mem_addr(mem_addr),
    .mem_data(mem_data), .display_on(display_on), .brightness(brightness),
    .frame_done(frame_done), .cmd_error(cmd_error)
  );

  always @(negedge CLOCK_50) begin
    if (frame_done === 1'b1) seen_frames++;
    if (cmd_error === 1'b1) seen_cmd_errs++;
  end

  initial begin
    repeat (90000) @(posedge CLOCK_50);
    $display("FAIL watchdog: got cycle budget exhausted, expected completion");
    $fatal(1, "bench did not complete");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b0; dio_i = b[i]; tick(HALF);
      sck = 1'b1; tick(HALF);
    end
  endtask

  task automatic cs_low;
    cs = 1'b0; tick(HALF);
  endtask

  task automatic cs_high;
    sck = 1'b1; cs = 1'b1; tick(HALF + 2);
  endtask

  task automatic model_reset;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_fixed = 1'b0; m_on = 1'b0; m_bright = 3'd0;
  endtask

  task automatic apply_reset;
    reset = 1'b0; tick(3);
    reset = 1'b1; tick(2);
    model_reset();
  endtask

  task automatic sample_mem(output logic [7:0] got [16]);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLOCK_50); mem_addr = 4'(i); #1; got[i] = mem_data;
    end
  endtask

  function automatic logic [7:0] key_expect(input logic [7:0] key, input int k);
    if (k >= 4) return 8'h00;
    return 8'((int'(key) >> k) % 2 + ((int'(key) >> (k + 4)) % 2) * 16);
  endfunction

  // Sends tx_q as one transaction and applies its meaning to the model.
  task automatic host_txn;
    logic [7:0] cmd;
    int ptr;
    cs_low();
    foreach (tx_q[i]) send_bits(tx_q[i], 8);
    cs_high();
    cmd = tx_q[0];
    case (int'(cmd) / 64)
      1: m_fixed = cmd[2];
      2: begin m_on = cmd[3]; m_bright = cmd[2:0]; end
      3: begin
        ptr = int'(cmd) % 16;
        for (int i = 1; i < tx_q.size(); i++) begin
          m_mem[ptr] = tx_q[i];
          if (!m_fixed) ptr = (ptr + 1) % 16;
        end
        if (tx_q.size() > 1) m_frames++;
      end
      default: m_cmd_errs++;
    endcase
  endtask

  task automatic read_txn(input logic [7:0] cmd, input int nbytes, input logic [7:0] key,
                          output logic [7:0] got [8], output logic oe_before,
                          output logic oe_ok, output logic stable_ok);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) got[k] = 8'h00;
    key_state = key;
    cs_low();
    oe_before = dio_e;
    send_bits(cmd, 8);
    m_fixed = cmd[2];
    oe_ok = 1'b1; stable_ok = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
        sck = 1'b0; dio_i = 1'b1; tick(HALF);
        b[i] = dio_o;
        if (dio_e !== 1'b1) oe_ok = 1'b0;
        sck = 1'b1; tick(HALF);
        if (dio_o !== b[i]) stable_ok = 1'b0;
      end
      got[k] = b;
      if (k == 0) key_state = 8'($urandom);
    end
    cs_high();
  endtask

  task automatic test_reset;
    logic [7:0] got [16];
    apply_reset();
    checks++; if (dio_e !== 1'b0) begin errors++; $display("FAIL reset_dio_e: got %b expected 0", dio_e); end
    checks++; if (dio_o !== 1'b0) begin errors++; $display("FAIL reset_dio_o: got %b expected 0", dio_o); end
    checks++; if (display_on !== 1'b0) begin errors++; $display("FAIL reset_display_on: got %b expected 0", display_on); end
    checks++; if (brightness !== 3'd0) begin errors++; $display("FAIL reset_brightness: got %0d expected 0", brightness); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL reset_cmd_error: got %b expected 0", cmd_error); end
    sample_mem(got);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== 8'h00) begin errors++; $display("FAIL reset_mem[%0d]: got %h expected 00", i, got[i]); end
    end
  endtask

  task automatic test_sequential_write;
    logic [7:0] got [16];
    int f0 = seen_frames, e0 = seen_cmd_errs;
    tx_q = '{8'h40}; host_txn();
    tx_q = '{8'hC0};
    for (int i = 1; i <= 16; i++) tx_q.push_back(8'(i));
    host_txn();
    sample_mem(got);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== m_mem[i]) begin errors++; $display("FAIL seq_mem[%0d]: got %h expected %h", i, got[i], m_mem[i]); end
    end
    checks++; if (seen_frames - f0 !== 1) begin errors++; $display("FAIL seq_frame_done: got %0d pulses expected 1", seen_frames - f0); end
    checks++; if (seen_cmd_errs - e0 !== 0) begin errors++; $display("FAIL seq_cmd_error: got %0d pulses expected 0", seen_cmd_errs - e0); end
  endtask

  task automatic test_fixed_mode;
    logic [7:0] got [16];
    tx_q = '{8'h44}; host_txn();
    tx_q = '{8'hC3, 8'hAA, 8'h55}; host_txn();
    sample_mem(got);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== m_mem[i]) begin errors++; $display("FAIL fixed_mem[%0d]: got %h expected %h", i, got[i], m_mem[i]); end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] got [16];
    tx_q = '{8'h40}; host_txn();
    tx_q = '{8'hCF, 8'h11, 8'h22}; host_txn();
    sample_mem(got);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== m_mem[i]) begin errors++; $display("FAIL wrap_mem[%0d]: got %h expected %h", i, got[i], m_mem[i]); end
    end
  endtask

  task automatic test_key_read;
    logic [7:0] got [8];
    logic oe_before, oe_ok, stable_ok;
    read_txn(8'h42, 5, 8'h81, got, oe_before, oe_ok, stable_ok);
    for (int k = 0; k < 5; k++) begin
      checks++; if (got[k] !== key_expect(8'h81, k)) begin errors++; $display("FAIL key_byte[%0d]: got %h expected %h", k, got[k], key_expect(8'h81, k)); end
    end
    checks++; if (oe_before !== 1'b0) begin errors++; $display("FAIL key_oe_before: got %b expected 0", oe_before); end
    checks++; if (oe_ok !== 1'b1) begin errors++; $display("FAIL key_oe_during: got %b expected 1", oe_ok); end
    checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL key_dio_stable: got %b expected 1", stable_ok); end
    checks++; if (dio_e !== 1'b0) begin errors++; $display("FAIL key_oe_after: got %b expected 0", dio_e); end
  endtask

  task automatic test_control;
    logic [7:0] got [16];
    int e0;
    tx_q = '{8'h8F}; host_txn();
    checks++; if (display_on !== m_on) begin errors++; $display("FAIL ctrl_on: got %b expected %b", display_on, m_on); end
    checks++; if (brightness !== m_bright) begin errors++; $display("FAIL ctrl_bright: got %0d expected %0d", brightness, m_bright); end
    e0 = seen_cmd_errs;
    tx_q = '{8'h23}; host_txn();
    checks++; if (seen_cmd_errs - e0 !== 1) begin errors++; $display("FAIL err_pulse: got %0d pulses expected 1", seen_cmd_errs - e0); end
    checks++; if (display_on !== m_on) begin errors++; $display("FAIL err_on: got %b expected %b", display_on, m_on); end
    checks++; if (brightness !== m_bright) begin errors++; $display("FAIL err_bright: got %0d expected %0d", brightness, m_bright); end
    sample_mem(got);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== m_mem[i]) begin errors++; $display("FAIL err_mem[%0d]: got %h expected %h", i, got[i], m_mem[i]); end
    end
  endtask

  task automatic test_partial_byte;
    logic [7:0] got [16];
    int f0 = seen_frames;
    cs_low();
    send_bits(8'hC5, 8);
    send_bits(8'h99, 4);
    cs_high();
    sample_mem(got);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== m_mem[i]) begin errors++; $display("FAIL partial_mem[%0d]: got %h expected %h", i, got[i], m_mem[i]); end
    end
    checks++; if (seen_frames - f0 !== 0) begin errors++; $display("FAIL partial_frame: got %0d pulses expected 0", seen_frames - f0); end
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] got [16];
    int f0;
    key_state = 8'hFF;
    cs_low();
    send_bits(8'h42, 8);
    sck = 1'b0; tick(HALF);
    checks++; if (dio_e !== 1'b1) begin errors++; $display("FAIL midread_oe: got %b expected 1", dio_e); end
    reset = 1'b0; @(negedge CLOCK_50);
    checks++; if (dio_e !== 1'b0) begin errors++; $display("FAIL midread_reset_oe: got %b expected 0", dio_e); end
    reset = 1'b1;
    model_reset();
    f0 = seen_frames;
    sck = 1'b1; tick(HALF);
    // CS never rose, so these bytes must not be treated as a transaction.
    send_bits(8'hC0, 8);
    send_bits(8'h77, 8);
    cs_high();
    sample_mem(got);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== m_mem[i]) begin errors++; $display("FAIL midread_mem[%0d]: got %h expected %h", i, got[i], m_mem[i]); end
    end
    checks++; if (seen_frames - f0 !== 0) begin errors++; $display("FAIL midread_frame: got %0d pulses expected 0", seen_frames - f0); end
    checks++; if (display_on !== 1'b0) begin errors++; $display("FAIL midread_on: got %b expected 0", display_on); end
  endtask

  task automatic test_random;
    logic [7:0] got [16];
    logic [7:0] rgot [8];
    logic [7:0] key;
    logic oe_before, oe_ok, stable_ok;
    int n;
    for (int t = 0; t < 24; t++) begin
      tx_q.delete();
      case ($urandom_range(0, 4))
        0: begin
          tx_q.push_back(8'hC0 | (8'($urandom) & 8'h3F));
          n = $urandom_range(1, 6);
          repeat (n) tx_q.push_back(8'($urandom));
          host_txn();
        end
        1, 2, 3: begin
          case ($urandom_range(1, 3))
            1: tx_q.push_back(8'h40 | (8'($urandom) & 8'h3D));
            2: tx_q.push_back(8'h80 | (8'($urandom) & 8'h3F));
            default: tx_q.push_back(8'($urandom) & 8'h3F);
          endcase
          n = $urandom_range(0, 2);
          repeat (n) tx_q.push_back(8'($urandom));
          host_txn();
        end
        default: begin
          key = 8'($urandom);
          n = $urandom_range(1, 6);
          read_txn(8'h42 | (8'($urandom) & 8'h3D), n, key, rgot, oe_before, oe_ok, stable_ok);
          for (int k = 0; k < n; k++) begin
            checks++; if (rgot[k] !== key_expect(key, k)) begin errors++; $display("FAIL rand_key[%0d][%0d]: got %h expected %h", t, k, rgot[k], key_expect(key, k)); end
          end
          checks++; if (oe_ok !== 1'b1) begin errors++; $display("FAIL rand_oe[%0d]: got %b expected 1", t, oe_ok); end
        end
      endcase
      checks++; if (display_on !== m_on) begin errors++; $display("FAIL rand_on[%0d]: got %b expected %b", t, display_on, m_on); end
      checks++; if (brightness !== m_bright) begin errors++; $display("FAIL rand_bright[%0d]: got %0d expected %0d", t, brightness, m_bright); end
    end
    sample_mem(got);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== m_mem[i]) begin errors++; $display("FAIL rand_mem[%0d]: got %h expected %h", i, got[i], m_mem[i]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    m_frames = seen_frames; m_cmd_errs = seen_cmd_errs;
    test_sequential_write();
    test_fixed_mode();
    test_wrap();
    test_key_read();
    test_control();
    test_partial_byte();
    test_reset_mid_read();
    test_random();
    checks++; if (seen_frames !== m_frames) begin errors++; $display("FAIL total_frames: got %0d expected %0d", seen_frames, m_frames); end
    checks++; if (seen_cmd_errs !== m_cmd_errs) begin errors++; $display("FAIL total_cmd_errors: got %0d expected %0d", seen_cmd_errs, m_cmd_errs); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
